// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache (32-byte lines) between the
// CPU memory stage and a 256-bit data memory with an enable/write/ack handshake.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | serving hits; a miss raises stall and starts the miss sequence
//   WRITEBACK | dirty victim line being written to memory, waiting for ack
//   REFILL    | requested line being read from memory, waiting for ack
//   FILL      | refill data on mem_data_i is written into the line this cycle
module dcache_controller #(
   parameter int INDEX_W = 5
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [31:0]   p1_addr_i,
   input  logic [31:0]   p1_data_i,
   input  logic          p1_MemRead_i,
   input  logic          p1_MemWrite_i,
   output logic [31:0]   p1_data_o,
   output logic          p1_stall_o,
   output logic [31:0]   mem_addr_o,
   output logic [255:0]  mem_data_o,
   output logic          mem_enable_o,
   output logic          mem_write_o,
   input  logic [255:0]  mem_data_i,
   input  logic          mem_ack_i
);

   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = 27 - INDEX_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, FILL} state_t;

   state_t             state_q, state_d;
   logic [LINES-1:0]   valid_q, valid_d;
   logic [LINES-1:0]   dirty_q, dirty_d;
   logic [TAG_W-1:0]   tag_q  [LINES];
   logic [255:0]       data_q [LINES];

   logic [TAG_W-1:0]   req_tag;
   logic [INDEX_W-1:0] req_idx;
   logic [2:0]         req_word;
   logic               req;
   logic               hit;
   logic               line_we;
   logic               tag_we;
   logic [255:0]       line_d;

   logic               stall;
   logic [31:0]        rdata;
   logic               men;
   logic               mwr;
   logic [31:0]        maddr;
   logic [255:0]       mdata;
   logic               unused_addr_bits;

   assign req_tag          = p1_addr_i[31:INDEX_W+5];
   assign req_idx          = p1_addr_i[INDEX_W+4:5];
   assign req_word         = p1_addr_i[4:2];
   assign unused_addr_bits = ^p1_addr_i[1:0];
   assign req              = p1_MemRead_i | p1_MemWrite_i;
   assign hit              = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      dirty_d = dirty_q;
      line_we = 1'b0;
      tag_we  = 1'b0;
      line_d  = data_q[req_idx];
      stall   = 1'b0;
      rdata   = '0;
      men     = 1'b0;
      mwr     = 1'b0;
      maddr   = '0;
      mdata   = '0;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  rdata = data_q[req_idx][{req_word, 5'b0} +: 32];
                  if (p1_MemWrite_i) begin
                     line_d[{req_word, 5'b0} +: 32] = p1_data_i;
                     line_we                        = 1'b1;
                     dirty_d[req_idx]               = 1'b1;
                  end
               end else begin
                  stall   = 1'b1;
                  state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : REFILL;
               end
            end
         end
         WRITEBACK: begin
            stall = 1'b1;
            men   = 1'b1;
            mwr   = 1'b1;
            maddr = {tag_q[req_idx], req_idx, 5'b0};
            mdata = data_q[req_idx];
            if (mem_ack_i) state_d = REFILL;
         end
         REFILL: begin
            stall = 1'b1;
            men   = 1'b1;
            maddr = {req_tag, req_idx, 5'b0};
            if (mem_ack_i) state_d = FILL;
         end
         FILL: begin
            stall            = 1'b1;
            line_d           = mem_data_i;
            line_we          = 1'b1;
            tag_we           = 1'b1;
            valid_d[req_idx] = 1'b1;
            dirty_d[req_idx] = 1'b0;
            state_d          = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are forced quiet during reset, whatever state the flops hold.
   assign p1_stall_o   = stall & ~rst_i;
   assign p1_data_o    = rst_i ? 32'd0 : rdata;
   assign mem_enable_o = men & ~rst_i;
   assign mem_write_o  = mwr & ~rst_i;
   assign mem_addr_o   = rst_i ? 32'd0 : maddr;
   assign mem_data_o   = rst_i ? 256'd0 : mdata;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && line_we) data_q[req_idx] <= line_d;
      if (!rst_i && tag_we)  tag_q[req_idx]  <= req_tag;
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: behavioural memory with fixed ack latency, a
// per-line cache model with a miss timeline, directed scenarios and random traffic.
module tb_dcache_controller;

   localparam int IW = 5;
   localparam int TW = 27 - IW;
   localparam int MEM_LAT = 10;

   logic         clk;
   logic         rst;
   logic [31:0]  addr;
   logic [31:0]  din;
   logic         re;
   logic         we;
   logic [31:0]  p1_data_o;
   logic         p1_stall_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;

   int vectors = 0;
   int miscompares = 0;

   dcache_controller #(.INDEX_W(IW)) dut (
      .clk_i(clk), .rst_i(rst),
      .p1_addr_i(addr), .p1_data_i(din),
      .p1_MemRead_i(re), .p1_MemWrite_i(we),
      .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
      .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural data memory ----------------
   logic [255:0] mem_arr [logic [31:0]];
   int           n_wr = 0, n_rd = 0;
   logic [31:0]  last_wr_a, last_rd_a;
   logic [255:0] last_wr_d;

   function automatic logic [255:0] init_line(input logic [31:0] a);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'h1000_0000 + a + 32'(w * 4);
      return l;
   endfunction

   function automatic logic [255:0] mem_line(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return init_line(a);
   endfunction

   initial begin : memory
      logic         busy, cur_wr, s_rst, s_en, s_wr, s_ack, nack;
      logic [31:0]  cur_a, s_a;
      logic [255:0] cur_d, s_d, nd;
      int           cnt;
      busy = 0; cur_wr = 0; cur_a = 0; cur_d = 0; cnt = 0;
      mem_ack_i = 0; mem_data_i = 0;
      forever begin
         @(negedge clk);
         s_rst = rst; s_en = mem_enable_o; s_wr = mem_write_o;
         s_a = mem_addr_o; s_d = mem_data_o; s_ack = mem_ack_i;
         @(posedge clk); #1;
         for (int w = 0; w < 8; w++) nd[w*32 +: 32] = $urandom;
         nack = 0;
         if (s_rst) busy = 0;
         else if (s_ack) begin
            busy = 0;
            if (cur_wr) begin
               mem_arr[cur_a] = cur_d; n_wr++; last_wr_a = cur_a; last_wr_d = cur_d;
            end else begin
               nd = mem_line(cur_a); n_rd++; last_rd_a = cur_a;
            end
         end else if (busy) begin
            cnt++;
            if (cnt == MEM_LAT - 1) nack = 1;
         end else if (s_en) begin
            busy = 1; cnt = 0; cur_wr = s_wr; cur_a = s_a; cur_d = s_d;
         end
         mem_ack_i  = nack;
         mem_data_i = nd;
      end
   end

   // ---------------- cache reference model + per-cycle compare ----------------
   bit           mv [32];
   bit           md [32];
   bit [TW-1:0]  mt [32];
   bit [255:0]   mdat [32];
   int           t = 0;
   bit           dirty_miss;
   bit [31:0]    vic_addr, req_addr;
   bit [255:0]   vic_line;

   always @(negedge clk) begin : model
      logic         e_stall, e_en, e_wr;
      logic [31:0]  e_data, e_addr;
      logic [255:0] e_mdata;
      int           li, wd, wbl;
      logic [TW-1:0] tg;
      e_stall = 0; e_en = 0; e_wr = 0; e_data = 0; e_addr = 0; e_mdata = 0;
      li = int'(addr[IW+4:5]); wd = int'(addr[4:2]); tg = addr[31:IW+5];
      if (rst) begin
         for (int i = 0; i < 32; i++) begin mv[i] = 0; md[i] = 0; end
         t = 0;
      end else if (t == 0) begin
         if (re || we) begin
            if (mv[li] && mt[li] == tg) begin
               e_data = mdat[li][wd*32 +: 32];
               if (we) begin mdat[li][wd*32 +: 32] = din; md[li] = 1; end
            end else begin
               e_stall    = 1;
               dirty_miss = mv[li] && md[li];
               vic_addr   = {mt[li], 5'(li), 5'b0};
               vic_line   = mdat[li];
               req_addr   = {addr[31:5], 5'b0};
               t = 1;
            end
         end
      end else begin
         e_stall = 1;
         wbl = dirty_miss ? MEM_LAT + 1 : 0;
         if (t <= wbl) begin
            e_en = 1; e_wr = 1; e_addr = vic_addr; e_mdata = vic_line;
         end else if (t <= wbl + MEM_LAT + 1) begin
            e_en = 1; e_addr = req_addr;
         end
         if (t == wbl + MEM_LAT + 2) begin
            mv[li] = 1; md[li] = 0; mt[li] = tg; mdat[li] = mem_line(req_addr); t = 0;
         end else t++;
      end
      chk("p1_stall_o", 256'(p1_stall_o), 256'(e_stall));
      chk("p1_data_o", 256'(p1_data_o), 256'(e_data));
      chk("mem_enable_o", 256'(mem_enable_o), 256'(e_en));
      chk("mem_write_o", 256'(mem_write_o), 256'(e_wr));
      chk("mem_addr_o", 256'(mem_addr_o), 256'(e_addr));
      chk("mem_data_o", mem_data_o, e_mdata);
   end

   // ---------------- CPU-side driver ----------------
   task automatic access(input logic [31:0] a, input logic [31:0] d, input logic r,
                         input logic w, output int stalls, output logic [31:0] rd);
      addr = a; din = d; re = r; we = w; stalls = 0; rd = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (!p1_stall_o) begin rd = p1_data_o; break; end
         stalls++;
      end
      if (stalls >= 80) begin
         vectors++; miscompares++;
         $display("FAIL access_timeout: stall still high after %0d cycles, addr %h", stalls, a);
      end
      @(posedge clk); #1;
      re = 0; we = 0;
   endtask

   initial begin : stim
      int          st, w0, r0;
      logic [31:0] rd;
      logic [255:0] wl;
      logic        s;
      rst = 1; addr = 0; din = 0; re = 0; we = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      // cold load of 0x40
      r0 = n_rd; w0 = n_wr;
      access(32'h40, 0, 1, 0, st, rd);
      chk("cold_stall_cycles", 256'(st), 256'd13);
      chk("cold_load_data", 256'(rd), 256'h1000_0040);
      chk("cold_reads", 256'(n_rd - r0), 256'd1);
      chk("cold_read_addr", 256'(last_rd_a), 256'h40);
      chk("cold_writes", 256'(n_wr - w0), 256'd0);

      // store hit, load hit
      r0 = n_rd; w0 = n_wr;
      access(32'h44, 32'hDEADBEEF, 0, 1, st, rd);
      chk("store_hit_stall", 256'(st), 256'd0);
      access(32'h44, 0, 1, 0, st, rd);
      chk("load_hit_stall", 256'(st), 256'd0);
      chk("load_hit_data", 256'(rd), 256'hDEADBEEF);
      chk("hit_mem_traffic", 256'(n_rd - r0 + n_wr - w0), 256'd0);

      // dirty eviction
      r0 = n_rd; w0 = n_wr;
      access(32'h440, 0, 1, 0, st, rd);
      wl = last_wr_d;
      chk("dirty_stall_cycles", 256'(st), 256'd24);
      chk("dirty_writes", 256'(n_wr - w0), 256'd1);
      chk("wb_addr", 256'(last_wr_a), 256'h40);
      chk("wb_word1", 256'(wl[63:32]), 256'hDEADBEEF);
      chk("wb_word0", 256'(wl[31:0]), 256'h1000_0040);
      chk("dirty_read_addr", 256'(last_rd_a), 256'h440);
      chk("dirty_load_data", 256'(rd), 256'h1000_0440);

      // clean eviction
      access(32'h80, 0, 1, 0, st, rd);
      w0 = n_wr;
      access(32'h480, 0, 1, 0, st, rd);
      chk("clean_stall_cycles", 256'(st), 256'd13);
      chk("clean_writes", 256'(n_wr - w0), 256'd0);

      // reload 0x40 (holds written-back word), then read+write both high on 0x48
      access(32'h44, 0, 1, 0, st, rd);
      chk("reload_wb_data", 256'(rd), 256'hDEADBEEF);
      access(32'h48, 32'h12345678, 1, 1, st, rd);
      chk("both_req_stall", 256'(st), 256'd0);
      access(32'h48, 0, 1, 0, st, rd);
      chk("both_req_load", 256'(rd), 256'h12345678);
      access(32'h448, 0, 1, 0, st, rd);
      chk("both_req_dirty_evict", 256'(st), 256'd24);

      // reset in cycle 5 of a refill
      addr = 32'h100; re = 1;
      repeat (5) @(posedge clk);
      #1 rst = 1; re = 0;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("post_reset_enable", 256'(mem_enable_o), 256'd0);
      chk("post_reset_stall", 256'(p1_stall_o), 256'd0);
      @(posedge clk); #1;
      access(32'h100, 0, 1, 0, st, rd);
      chk("post_reset_remiss", 256'(st), 256'd13);

      // random traffic over a few indexes and aliasing tags
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk); s = p1_stall_o;
         @(posedge clk); #1;
         if (rst) rst = 0;
         else if ($urandom_range(0, 99) == 0) begin rst = 1; re = 0; we = 0; end
         else if (!s) begin
            addr = {22'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
            din  = $urandom;
            case ($urandom_range(0, 3))
               0: begin re = 0; we = 0; end
               1: begin re = 1; we = 0; end
               2: begin re = 0; we = 1; end
               default: begin re = 1; we = 1; end
            endcase
         end
      end
      rst = 0; re = 0; we = 0;
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate L1 data cache between the CPU memory stage and the 256-bit off-chip data memory. It serves 32-bit CPU loads and stores in the same cycle on a hit. On a miss it stalls the pipeline, writes back a dirty victim line if needed, and refills the line over the data memory's enable/write/ack handshake.

## Interface
- `INDEX_W`, default 5: index bits; the cache has 2^INDEX_W lines of 32 bytes each. The tag is `32-5-INDEX_W` bits.
- `clk_i` in, 1: clock; all state changes on the rising edge.
- `rst_i` in, 1: synchronous, active-high reset.
- `p1_addr_i` in, 32: CPU byte address. `[4:2]` is the word in the line, `[INDEX_W+4:5]` is the index, the upper bits are the tag, and `[1:0]` is ignored.
- `p1_data_i` in, 32: store data.
- `p1_MemRead_i` in, 1: load request.
- `p1_MemWrite_i` in, 1: store request; takes priority if both request inputs are high.
- `p1_data_o` out, 32: load data, combinational from the indexed line.
- `p1_stall_o` out, 1: pipeline stall. The CPU holds address, data and requests stable while it is high.
- `mem_addr_o` out, 32: line address with `[4:0]=0`.
- `mem_data_o` out, 256: victim line for write-back.
- `mem_enable_o` out, 1: memory request.
- `mem_write_o` out, 1: 1 = write-back, 0 = refill read.
- `mem_data_i` in, 256: refill line; valid in the cycle after `mem_ack_i`.
- `mem_ack_i` in, 1: one-cycle completion pulse from memory.

## Operation
- **Storage (flops):** per line, `valid`, `dirty`, tag and 256-bit data.
  - Hit = `valid && tag == p1_addr_i` tag field.
- **Reset:** clears all valid and dirty bits and forces state to IDLE. Data and tag contents are don't-care.
- **States:** IDLE, WRITEBACK, REFILL, FILL.
- **IDLE, no request:** all outputs low.
- **IDLE, hit:**
  - `p1_stall_o=0`.
  - `p1_data_o` = selected word.
  - On a store, the word is written at the clock edge and `dirty` is set.
- **IDLE, miss:**
  - `p1_stall_o=1` in the same cycle.
  - Go to WRITEBACK if the victim is valid and dirty, otherwise to REFILL.
- **WRITEBACK:**
  - `mem_enable_o=1`, `mem_write_o=1`, `mem_addr_o={victim_tag,index,5'b0}`, `mem_data_o` = victim line.
  - On `mem_ack_i`, go to REFILL.
- **REFILL:**
  - `mem_enable_o=1`, `mem_write_o=0`, `mem_addr_o={req_tag,index,5'b0}`.
  - On `mem_ack_i`, go to FILL.
- **FILL:**
  - `mem_enable_o=0`.
  - At the edge, capture `mem_data_i` into the line, write the tag, set `valid=1`, `dirty=0`, then go to IDLE.
  - The held request then hits in IDLE.
- **Stall:** `p1_stall_o=1` in every non-IDLE state.
- **Memory-side outputs:** `mem_addr_o` and `mem_data_o` are 0 in IDLE and FILL.
- `mem_ack_i` is ignored in IDLE and FILL.
- The enable must drop in FILL. The memory re-arms from its idle state on any enable in the cycle after ack.
- WRITEBACK→REFILL keeps enable high with `mem_write_o` falling. The memory samples the write flag while idle, so back-to-back transactions are legal.
- The victim line is not modified before the write-back ack, so `mem_data_o` is stable through the ack cycle.
- **Reset mid-miss:** return to IDLE immediately and drop `mem_enable_o`; nothing is written to the arrays. System reset resets the memory too.

## Timing
- **Hit:** zero added latency (combinational read, single-edge write).
- **Memory:** acks 10 cycles after it first samples enable.
- **Clean miss:** request seen in cycle 0.
  - REFILL in cycles 1–11, ack in cycle 11.
  - FILL in cycle 12, hit in cycle 13.
  - Stall is high for exactly 13 cycles.
- **Dirty miss:**
  - WRITEBACK in cycles 1–11, REFILL in cycles 12–22.
  - FILL in cycle 23, hit in cycle 24.
  - Stall is high for 24 cycles.
- **Outputs during reset:** all outputs 0 while `rst_i` is high.
- **After reset:** any request misses.

## Test plan
- **Reset then cold load:** reset, then load 0x0000_0040.
  - Stall high 13 cycles; one memory read with `mem_addr_o=0x40` and `mem_write_o=0`.
  - `p1_data_o` = word 0 of memory line 2.
- **Store hit then load hit:** store 0xDEADBEEF to 0x44 after a refill, then load 0x44.
  - No stall on either access.
  - Load returns 0xDEADBEEF; no memory enable seen.
- **Dirty eviction:** dirty line at 0x40, then load 0x440 (same index, `INDEX_W=5`).
  - A write of the 256-bit line to 0x40 (old line with 0xDEADBEEF in word 1), then a read of 0x440.
  - Stall high 24 cycles.
- **Clean eviction:** clean line at 0x80, then load 0x480.
  - No write-back; stall high 13 cycles.
- **Simultaneous read and write:** both requests high on a hit to 0x48 with data 0x12345678.
  - Treated as a store; dirty set; a subsequent load returns 0x12345678.
- **Reset mid-refill:** `rst_i` high in cycle 5 of a REFILL.
  - Next cycle: state IDLE, `mem_enable_o=0`, stall low.
  - The same address then misses again.
